// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared types and constants for the fetch sequencer.
//   fetch_state_t : RUN / STALL / FLUSH / HALT (2-bit encoding, also exported on the debug port)
//   NOP_INSTR     : LEGv8 NOP loaded into IF/ID when ifid_flush is asserted
package fetch_ctrl_pkg;
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;
    localparam logic [31:0] NOP_INSTR = 32'hD503201F;
endpackage

// File: rtl/fetch_ctrl_stall_timer.sv
// stall_timer: loadable down counter that times load-use freezes.
//   clk, reset   : clock, asynchronous active-low reset (count cleared)
//   load         : load load_val at the next edge (wins over dec)
//   load_val     : value to load
//   dec          : decrement at the next edge; the count never goes below zero
//   zero         : the count after the coming edge is zero
module stall_timer #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load ? load_val : (dec && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    // Looking at the next value lets the FSM leave STALL on the edge where the count expires.
    assign zero = (cnt_d == '0);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequencer for the LEGv8 instruction-fetch / PC datapath.
//   clk, reset             : clock, asynchronous active-low reset (all outputs forced to 0 while low)
//   br_req, br_uncond,
//   br_cond_true           : branch in register fetch, its form, and its condition
//   ld_use_hazard          : load-use stall request from decode
//   halt_req, resume       : level halt request, single-cycle resume pulse
//   pc_wren, ifid_wren     : PC and IF/ID write enables
//   ifid_flush             : IF/ID loads NOP_INSTR at the next edge
//   BrTaken, UncondBr      : PC next-address mux selects
//   state                  : current FSM state (debug)
//   br_count               : taken-branch counter, built only with FETCH_CTRL_BRCNT_EN defined
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = $clog2(STALL_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        br_req,
    input  logic        br_uncond,
    input  logic        br_cond_true,
    input  logic        ld_use_hazard,
    input  logic        halt_req,
    input  logic        resume,
    output logic        pc_wren,
    output logic        ifid_wren,
    output logic        ifid_flush,
    output logic        BrTaken,
    output logic        UncondBr,
    output logic [1:0]  state,
    output logic [31:0] br_count
);
    fetch_state_t state_q, state_d;
    logic pc_c, ifid_c, flush_c, br_c, unc_c, load, zero;
    wire  taken = br_req & (br_uncond | br_cond_true);

    stall_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (CNT_W'(STALL_CYCLES - 1)),
        .dec      (state_q == STALL),
        .zero     (zero)
    );

    // The hazard cycle itself is the first frozen cycle, so STALL lasts STALL_CYCLES-1
    // cycles; with STALL_CYCLES=1 the timer loads zero and the FSM stays in RUN.
    always_comb begin
        state_d = state_q;
        pc_c    = 1'b0;
        ifid_c  = 1'b0;
        flush_c = 1'b0;
        br_c    = 1'b0;
        unc_c   = 1'b0;
        load    = 1'b0;
        case (state_q)
            RUN: begin
                unc_c = br_req & br_uncond;
                if (ld_use_hazard) begin
                    load    = 1'b1;
                    state_d = zero ? RUN : STALL;
                end else if (taken) begin
                    br_c    = 1'b1;
                    pc_c    = 1'b1;
                    ifid_c  = 1'b1;
                    flush_c = 1'b1;
                    state_d = FLUSH;
                end else if (halt_req) begin
                    state_d = HALT;
                end else begin
                    pc_c   = 1'b1;
                    ifid_c = 1'b1;
                end
            end
            STALL: state_d = zero ? RUN : STALL;
            FLUSH: begin
                pc_c    = 1'b1;
                ifid_c  = 1'b1;
                state_d = halt_req ? HALT : RUN;
            end
            HALT:  state_d = resume ? RUN : HALT;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= RUN;
        else        state_q <= state_d;
    end

    assign pc_wren    = reset & pc_c;
    assign ifid_wren  = reset & ifid_c;
    assign ifid_flush = reset & flush_c;
    assign BrTaken    = reset & br_c;
    assign UncondBr   = reset & unc_c;
    assign state      = state_q;

`ifdef FETCH_CTRL_BRCNT_EN
    logic [31:0] br_count_q, br_count_d;
    always_comb br_count_d = br_count_q + {31'd0, BrTaken};
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) br_count_q <= '0;
        else        br_count_q <= br_count_d;
    end
    assign br_count = br_count_q;
`else
    assign br_count = 32'd0;
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed, table-driven check of fetch_ctrl with STALL_CYCLES=3.
module tb_fetch_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        br_req, br_uncond, br_cond_true, ld_use_hazard, halt_req, resume;
    logic        pc_wren, ifid_wren, ifid_flush, BrTaken, UncondBr;
    logic [1:0]  state;
    logic [31:0] br_count;
    int passed = 0;
    int total  = 0;

    // in  = {br_req, br_uncond, br_cond_true, ld_use_hazard, halt_req, resume}
    // exp = {pc_wren, ifid_wren, ifid_flush, BrTaken, UncondBr, state[1:0]}
    typedef struct packed {
        logic [5:0] in;
        logic [6:0] exp;
    } vec_t;
    vec_t vq[$];

    fetch_ctrl #(.STALL_CYCLES(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .br_req        (br_req),
        .br_uncond     (br_uncond),
        .br_cond_true  (br_cond_true),
        .ld_use_hazard (ld_use_hazard),
        .halt_req      (halt_req),
        .resume        (resume),
        .pc_wren       (pc_wren),
        .ifid_wren     (ifid_wren),
        .ifid_flush    (ifid_flush),
        .BrTaken       (BrTaken),
        .UncondBr      (UncondBr),
        .state         (state),
        .br_count      (br_count)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [5:0] v);
        {br_req, br_uncond, br_cond_true, ld_use_hazard, halt_req, resume} = v;
    endtask

    function automatic logic [6:0] outs();
        return {pc_wren, ifid_wren, ifid_flush, BrTaken, UncondBr, state};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    initial begin
        logic [31:0] exp_cnt;
`ifdef FETCH_CTRL_BRCNT_EN
        exp_cnt = 32'd5;
`else
        exp_cnt = 32'd0;
`endif
        vq.push_back('{6'b000000, 7'b1100000});
        vq.push_back('{6'b101000, 7'b1111000});
        vq.push_back('{6'b000000, 7'b1100010});
        vq.push_back('{6'b000000, 7'b1100000});
        vq.push_back('{6'b100000, 7'b1100000});
        vq.push_back('{6'b110100, 7'b0000100});
        vq.push_back('{6'b110000, 7'b0000001});
        vq.push_back('{6'b110000, 7'b0000001});
        vq.push_back('{6'b110000, 7'b1111100});
        vq.push_back('{6'b110000, 7'b1100010});
        vq.push_back('{6'b110000, 7'b1111100});
        vq.push_back('{6'b110000, 7'b1100010});
        vq.push_back('{6'b000010, 7'b0000000});
        vq.push_back('{6'b000000, 7'b0000011});
        vq.push_back('{6'b000001, 7'b0000011});
        vq.push_back('{6'b000000, 7'b1100000});
        vq.push_back('{6'b000001, 7'b1100000});
        vq.push_back('{6'b000000, 7'b1100000});
        vq.push_back('{6'b101000, 7'b1111000});
        vq.push_back('{6'b000010, 7'b1100010});
        vq.push_back('{6'b000000, 7'b0000011});
        vq.push_back('{6'b000001, 7'b0000011});
        vq.push_back('{6'b000110, 7'b0000000});
        vq.push_back('{6'b000110, 7'b0000001});
        vq.push_back('{6'b000010, 7'b0000001});
        vq.push_back('{6'b000010, 7'b0000000});
        vq.push_back('{6'b000001, 7'b0000011});
        vq.push_back('{6'b000000, 7'b1100000});
        vq.push_back('{6'b110000, 7'b1111100});
        vq.push_back('{6'b000000, 7'b1100010});

        drive(6'b111111);
        repeat (3) begin
            @(negedge clk);
            #1;
            check("reset_outs", 32'(outs()), 32'd0);
        end
        check("reset_br_count", br_count, 32'd0);

        reset = 1'b1;
        foreach (vq[i]) begin
            drive(vq[i].in);
            #1;
            check($sformatf("vec%0d", i + 1), 32'(outs()), 32'(vq[i].exp));
            @(negedge clk);
        end
        check("br_count_after_5", br_count, exp_cnt);

        drive(6'b111111);
        reset = 1'b0;
        #1;
        check("midrun_reset_outs", 32'(outs()), 32'd0);
        check("midrun_reset_br_count", br_count, 32'd0);
        repeat (3) begin
            @(negedge clk);
            #1;
            check("midrun_reset_hold", 32'(outs()), 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        drive(6'b000000);
        #1;
        check("after_reset_run", 32'(outs()), 32'(7'b1100000));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
